// File: rtl/sevseg_pkg.sv
// Shared types for the seven-segment display arbiter: hex digits, the
// four-digit display word, and the arbiter state encoding.
package sevseg_pkg;

    typedef logic [3:0] hex_digit_t;

    // Index 3 is the leftmost digit (in3), index 0 the rightmost (in0).
    typedef hex_digit_t [3:0] disp_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ = 3;

endpackage

// File: rtl/sevseg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i,
// wrapping modulo N.
module rr_pick
    import sevseg_pkg::*;
#(
    parameter int N  = DEF_NREQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int j;
        j        = 0;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sevseg_display_arbiter.sv
// Round-robin time-sharing of the 4-digit seven-segment display among NREQ
// requesters. Define SEVSEG_PREEMPT_EN to make requester 0 preempt on its rising edge.
module sevseg_display_arbiter
    import sevseg_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*16-1:0]      data,
    output logic [3:0]              in3,
    output logic [3:0]              in2,
    output logic [3:0]              in1,
    output logic [3:0]              in0,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    active
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    disp_word_t      disp_q, disp_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            owner_req;
    logic            rearb;
    logic            preempt;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // A dropped owner has its req bit low, so the raw req vector already excludes it.
    rr_pick #(
        .N (NREQ),
        .IW(IW)
    ) u_pick (
        .req_i   (req),
        .start_i (rr_q),
        .onehot_o(pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    assign owner_req = |(req & grant_q);

`ifdef SEVSEG_PREEMPT_EN
    logic req0_q;
    assign preempt = (state_q == SHOW) && req[0] && !req0_q && (owner_q != '0);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
`ifdef SEVSEG_PREEMPT_EN
            req0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
`ifdef SEVSEG_PREEMPT_EN
            req0_q  <= req[0];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        rearb   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = RELOAD;
                rearb = 1'b1;
            end
            SHOW: begin
                if (!owner_req || cnt_q == '0) begin
                    rearb = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Preemption leaves rr untouched so the rotation resumes where it was.
        if (preempt) begin
            state_d = SHOW;
            grant_d = NREQ'(1);
            owner_d = '0;
            cnt_d   = RELOAD;
        end else if (rearb) begin
            if (pick_vld) begin
                state_d = SHOW;
                grant_d = pick_oh;
                owner_d = pick_idx;
                cnt_d   = RELOAD;
                rr_d    = wrap_inc(pick_idx);
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
            end
        end
    end

    always_comb begin
        disp_d = '0;
        if (state_d == SHOW) begin
            disp_d = disp_word_t'(data[16*int'(owner_d) +: 16]);
        end
        in3    = disp_q[3];
        in2    = disp_q[2];
        in1    = disp_q[1];
        in0    = disp_q[0];
        grant  = grant_q;
        owner  = owner_q;
        active = (state_q == SHOW);
    end

endmodule
